// File: rtl/dma_fmi_tile_loader.sv
// Loads one TIX x TIY x TIF feature-map tile from external memory into FMI RAM,
// zero-filling out-of-image positions and keeping up to MAX_OUT reads in flight.
module dma_fmi_tile_loader #(
    parameter  int unsigned TIX        = 4,
    parameter  int unsigned TIY        = 4,
    parameter  int unsigned TIF        = 8,
    parameter  int unsigned DATA_W     = 16,
    parameter  int unsigned EXT_ADDR_W = 32,
    parameter  int unsigned MAX_OUT    = 4,
    localparam int unsigned FMI_N_ELEM = TIX * TIY * TIF,
    localparam int unsigned FMI_ADDR_W = $clog2(FMI_N_ELEM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [EXT_ADDR_W-1:0] cfg_base,
    input  logic [15:0]           cfg_row_stride,
    input  logic [EXT_ADDR_W-1:0] cfg_plane_stride,
    input  logic [15:0]           cfg_x0,
    input  logic [15:0]           cfg_y0,
    input  logic [15:0]           cfg_img_w,
    input  logic [15:0]           cfg_img_h,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [EXT_ADDR_W-1:0] rd_req_addr,
    input  logic                  rd_rsp_valid,
    input  logic [DATA_W-1:0]     rd_rsp_data,
    output logic                  fmi_we,
    output logic [FMI_ADDR_W-1:0] fmi_addr,
    output logic [DATA_W-1:0]     fmi_wdata
);
    localparam int unsigned TX_W  = (TIX > 1) ? $clog2(TIX) : 1;
    localparam int unsigned TY_W  = (TIY > 1) ? $clog2(TIY) : 1;
    localparam int unsigned TF_W  = (TIF > 1) ? $clog2(TIF) : 1;
    localparam int unsigned PTR_W = $clog2(MAX_OUT);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [EXT_ADDR_W-1:0]   base_q, base_d, plane_q, plane_d;
    logic [15:0]             row_q, row_d, x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
    logic [TX_W-1:0]         tx_q, tx_d, ntx;
    logic [TY_W-1:0]         ty_q, ty_d, nty;
    logic [TF_W-1:0]         tf_q, tf_d, ntf;
    logic [FMI_ADDR_W-1:0]   idx_q, idx_d;
    logic                    pad_q, pad_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FMI_ADDR_W-1:0]   tag_q [MAX_OUT];
    logic                    busy_q, busy_d, done_q, done_d;
    logic                    rd_req_valid_q, rd_req_valid_d;
    logic [EXT_ADDR_W-1:0]   rd_req_addr_q, rd_req_addr_d;
    logic                    fmi_we_q, fmi_we_d;
    logic [FMI_ADDR_W-1:0]   fmi_addr_q, fmi_addr_d;
    logic [DATA_W-1:0]       fmi_wdata_q, fmi_wdata_d;

    logic [EXT_ADDR_W-1:0]   sel_base, sel_plane, n_addr;
    logic [15:0]             sel_row, sel_x0, sel_y0, sel_w, sel_h;
    logic signed [16:0]      gx, gy;
    logic                    n_pad, rsp_wr, fire, pad_wr, adv, last;

    // Next scan position and its pad decision / external address; live cfg on start.
    always_comb begin
        sel_base  = (state_q == S_IDLE) ? cfg_base         : base_q;
        sel_plane = (state_q == S_IDLE) ? cfg_plane_stride : plane_q;
        sel_row   = (state_q == S_IDLE) ? cfg_row_stride   : row_q;
        sel_x0    = (state_q == S_IDLE) ? cfg_x0           : x0_q;
        sel_y0    = (state_q == S_IDLE) ? cfg_y0           : y0_q;
        sel_w     = (state_q == S_IDLE) ? cfg_img_w        : w_q;
        sel_h     = (state_q == S_IDLE) ? cfg_img_h        : h_q;
        ntx = tx_q + TX_W'(1);
        nty = ty_q;
        ntf = tf_q;
        if (tx_q == TX_W'(TIX - 1)) begin
            ntx = '0;
            nty = ty_q + TY_W'(1);
            if (ty_q == TY_W'(TIY - 1)) begin
                nty = '0;
                ntf = tf_q + TF_W'(1);
            end
        end
        if (state_q == S_IDLE) begin
            ntx = '0;
            nty = '0;
            ntf = '0;
        end
        gx = {sel_x0[15], sel_x0} + 17'(ntx);
        gy = {sel_y0[15], sel_y0} + 17'(nty);
        n_pad = (gx < 17'sd0) || (gx >= $signed({1'b0, sel_w}))
             || (gy < 17'sd0) || (gy >= $signed({1'b0, sel_h}));
        n_addr = sel_base + EXT_ADDR_W'(ntf) * sel_plane
               + EXT_ADDR_W'(gy[15:0]) * EXT_ADDR_W'(sel_row) + EXT_ADDR_W'(gx[15:0]);
    end

    // FSM, issue stage, tag FIFO bookkeeping and FMI write arbitration.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        plane_d  = plane_q;
        row_d    = row_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        tf_d     = tf_q;
        idx_d    = idx_q;
        pad_d    = pad_q;
        rd_req_addr_d = rd_req_addr_q;

        rsp_wr = rd_rsp_valid && (state_q != S_IDLE) && (cnt_q != '0);
        fire   = rd_req_valid_q && rd_req_ready;
        pad_wr = (state_q == S_RUN) && pad_q && !rsp_wr;
        adv    = fire || pad_wr;
        last   = (idx_q == FMI_ADDR_W'(FMI_N_ELEM - 1));

        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RUN;
                base_d  = cfg_base;
                plane_d = cfg_plane_stride;
                row_d   = cfg_row_stride;
                x0_d    = cfg_x0;
                y0_d    = cfg_y0;
                w_d     = cfg_img_w;
                h_d     = cfg_img_h;
                tx_d    = '0;
                ty_d    = '0;
                tf_d    = '0;
                idx_d   = '0;
                pad_d   = n_pad;
                rd_req_addr_d = n_addr;
            end
            S_RUN: if (adv) begin
                if (last) begin
                    state_d = S_DRAIN;
                end else begin
                    tx_d  = ntx;
                    ty_d  = nty;
                    tf_d  = ntf;
                    idx_d = idx_q + FMI_ADDR_W'(1);
                    pad_d = n_pad;
                    rd_req_addr_d = n_addr;
                end
            end
            S_DRAIN: if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        cnt_d    = cnt_q + CNT_W'(fire) - CNT_W'(rsp_wr);
        wr_ptr_d = wr_ptr_q + PTR_W'(fire);
        rd_ptr_d = rd_ptr_q + PTR_W'(rsp_wr);
        // Valid is registered, so it looks ahead at next-cycle occupancy.
        rd_req_valid_d = (state_d == S_RUN) && !pad_d && (cnt_d < CNT_W'(MAX_OUT));
        busy_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d   = (state_d == S_DONE);

        fmi_we_d    = rsp_wr || pad_wr;
        fmi_addr_d  = rsp_wr ? tag_q[rd_ptr_q] : (pad_wr ? idx_q : '0);
        fmi_wdata_d = rsp_wr ? rd_rsp_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            base_q         <= '0;
            plane_q        <= '0;
            row_q          <= '0;
            x0_q           <= '0;
            y0_q           <= '0;
            w_q            <= '0;
            h_q            <= '0;
            tx_q           <= '0;
            ty_q           <= '0;
            tf_q           <= '0;
            idx_q          <= '0;
            pad_q          <= 1'b0;
            cnt_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            rd_req_valid_q <= 1'b0;
            rd_req_addr_q  <= '0;
            fmi_we_q       <= 1'b0;
            fmi_addr_q     <= '0;
            fmi_wdata_q    <= '0;
            for (int i = 0; i < int'(MAX_OUT); i++) tag_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            plane_q        <= plane_d;
            row_q          <= row_d;
            x0_q           <= x0_d;
            y0_q           <= y0_d;
            w_q            <= w_d;
            h_q            <= h_d;
            tx_q           <= tx_d;
            ty_q           <= ty_d;
            tf_q           <= tf_d;
            idx_q          <= idx_d;
            pad_q          <= pad_d;
            cnt_q          <= cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            rd_req_valid_q <= rd_req_valid_d;
            rd_req_addr_q  <= rd_req_addr_d;
            fmi_we_q       <= fmi_we_d;
            fmi_addr_q     <= fmi_addr_d;
            fmi_wdata_q    <= fmi_wdata_d;
            if (fire) tag_q[wr_ptr_q] <= idx_q;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign rd_req_valid = rd_req_valid_q;
    assign rd_req_addr  = rd_req_addr_q;
    assign fmi_we       = fmi_we_q;
    assign fmi_addr     = fmi_addr_q;
    assign fmi_wdata    = fmi_wdata_q;

    // A response with no request in flight is a protocol error (dropped in hardware).
    rsp_has_tag: assert property (@(posedge clk) disable iff (!rst_n)
        (rd_rsp_valid && (state_q != S_IDLE)) |-> (cnt_q != '0));

endmodule

// File: tb/tb_dma_fmi_tile_loader.sv
// Randomized bench for dma_fmi_tile_loader: memory/latency model drives the read port,
// a tile-level reference model predicts request addresses and final FMI contents.
module tb_dma_fmi_tile_loader;
    localparam int N = 128;
    localparam int TX = 4;
    localparam int TY = 4;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [31:0] cfg_base, cfg_plane_stride;
    logic [15:0] cfg_row_stride, cfg_x0, cfg_y0, cfg_img_w, cfg_img_h;
    logic        busy, done, rd_req_valid, rd_req_ready, rd_rsp_valid, fmi_we;
    logic [31:0] rd_req_addr;
    logic [15:0] rd_rsp_data, fmi_wdata;
    logic [6:0]  fmi_addr;

    dma_fmi_tile_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_base(cfg_base), .cfg_row_stride(cfg_row_stride),
        .cfg_plane_stride(cfg_plane_stride), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0),
        .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h),
        .busy(busy), .done(done),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .fmi_we(fmi_we), .fmi_addr(fmi_addr), .fmi_wdata(fmi_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_pct = 100;
    int lat_cfg = 3;
    int n_req, done_cnt, done_cyc, start_cyc, stall_err, busy_err, tb_out, max_out;
    logic [31:0] first_addr, prev_addr;
    logic        prev_stall;
    logic [15:0] exp_fmi [N];
    logic [15:0] fmi_log [N];
    int          wr_cnt [N];
    logic [31:0] exp_req [$];
    int          due_q [$];
    logic [15:0] dat_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_data(input logic [31:0] a);
        logic [31:0] t;
        t = a * 32'h9E3779B1;
        return t[31:16] ^ a[15:0];
    endfunction

    // External memory: fixed-latency, in-order responses; FMI and handshake logging.
    initial begin
        rd_req_ready = 1'b0;
        rd_rsp_valid = 1'b0;
        rd_rsp_data  = '0;
        prev_stall   = 1'b0;
        prev_addr    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            rd_req_ready = ($urandom_range(99) < ready_pct);
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                rd_rsp_valid = 1'b1;
                rd_rsp_data  = dat_q.pop_front();
                void'(due_q.pop_front());
                tb_out--;
            end else begin
                rd_rsp_valid = 1'b0;
                rd_rsp_data  = '0;
            end
            if (rst_n && rd_req_valid && rd_req_ready) begin
                n_req++;
                if (n_req == 1) first_addr = rd_req_addr;
                if (exp_req.size() > 0) check("req_addr", rd_req_addr, exp_req.pop_front());
                due_q.push_back(cyc + lat_cfg);
                dat_q.push_back(mem_data(rd_req_addr));
                tb_out++;
                if (tb_out > max_out) max_out = tb_out;
            end
            if (prev_stall && rd_req_addr !== prev_addr) stall_err++;
            prev_stall = rst_n && rd_req_valid && !rd_req_ready;
            prev_addr  = rd_req_addr;
            if (fmi_we) begin
                wr_cnt[fmi_addr]++;
                fmi_log[fmi_addr] = fmi_wdata;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) busy_err++;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        #1 start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        #1 start = 1'b0;
    endtask

    // mode 0: normal run, 1: second start mid-run, 2: reset after 20 requests
    task automatic run_test(input string name, input logic [31:0] base, input int row,
                            input logic [31:0] plane, input int x0, input int y0,
                            input int w, input int h, input int rp, input int lt,
                            input int mode);
        int gx, gy, stale, bad_cnt, nreq_exp;
        logic [31:0] a;
        exp_req.delete();
        nreq_exp = 0;
        for (int k = 0; k < N; k++) begin
            gx = x0 + (k % TX);
            gy = y0 + ((k / TX) % TY);
            if (gx < 0 || gx >= w || gy < 0 || gy >= h) begin
                exp_fmi[k] = '0;
            end else begin
                a = 32'(longint'(base) + longint'(k / (TX * TY)) * longint'(plane)
                        + longint'(gy) * longint'(row) + longint'(gx));
                exp_req.push_back(a);
                exp_fmi[k] = mem_data(a);
                nreq_exp++;
            end
            wr_cnt[k]  = 0;
            fmi_log[k] = 'x;
        end
        n_req = 0; done_cnt = 0; done_cyc = 0; stall_err = 0; busy_err = 0;
        tb_out = 0; max_out = 0; first_addr = 'x;
        ready_pct = rp;
        lat_cfg   = lt;
        cfg_base = base; cfg_row_stride = 16'(row); cfg_plane_stride = plane;
        cfg_x0 = 16'(x0); cfg_y0 = 16'(y0); cfg_img_w = 16'(w); cfg_img_h = 16'(h);
        pulse_start();
        if (mode == 1) begin
            repeat (20) @(negedge clk);
            #1;
            cfg_base = 32'h2000; cfg_x0 = 16'hFFFF; cfg_y0 = 16'd7; cfg_row_stride = 16'd5;
            start = 1'b1;
            @(negedge clk);
            #1 start = 1'b0;
        end
        if (mode == 2) begin
            for (int i = 0; i < 2000 && n_req < 20; i++) @(negedge clk);
            check({name, "_reach20"}, n_req >= 20, 1);
            #1 rst_n = 1'b0;
            @(negedge clk);
            check({name, "_rst_busy"}, busy, 0);
            check({name, "_rst_valid"}, rd_req_valid, 0);
            check({name, "_rst_addr"}, rd_req_addr, 0);
            check({name, "_rst_we"}, {fmi_we, fmi_addr, fmi_wdata, done}, 0);
            @(negedge clk);
            #1 rst_n = 1'b1;
            stale = 0;
            repeat (12) begin
                @(negedge clk);
                if (fmi_we || busy || rd_req_valid || done) stale++;
            end
            check({name, "_idle_after_rst"}, stale, 0);
            check({name, "_rsp_drained"}, due_q.size(), 0);
            return;
        end
        for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_busy_at_done"}, busy_err, 0);
        check({name, "_busy_end"}, busy, 0);
        check({name, "_nreq"}, n_req, nreq_exp);
        check({name, "_req_left"}, exp_req.size(), 0);
        check({name, "_stall_addr"}, stall_err, 0);
        check({name, "_max_out"}, max_out <= 4, 1);
        bad_cnt = 0;
        for (int k = 0; k < N; k++) if (wr_cnt[k] != 1) bad_cnt++;
        check({name, "_write_once"}, bad_cnt, 0);
        for (int k = 0; k < N; k++) check({name, "_fmi"}, fmi_log[k], exp_fmi[k]);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        cfg_base = '0; cfg_plane_stride = '0; cfg_row_stride = '0;
        cfg_x0 = '0; cfg_y0 = '0; cfg_img_w = '0; cfg_img_h = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", {busy, done, rd_req_valid, fmi_we}, 0);
        check("reset_addr", rd_req_addr, 0);
        check("reset_fmi", {fmi_addr, fmi_wdata}, 0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_test("inbounds", 32'h1000, 32, 32'd1024, 4, 4, 32, 32, 100, 3, 0);
        check("inbounds_first", first_addr, 32'h1084);
        check("inbounds_nreq128", n_req, 128);

        run_test("corner", 32'h1000, 32, 32'd1024, -1, -1, 32, 32, 100, 3, 0);
        check("corner_first", first_addr, 32'h1000);
        check("corner_nreq72", n_req, 72);

        run_test("backpr", 32'h1000, 32, 32'd1024, 4, 4, 32, 32, 30, 10, 0);
        check("backpr_out_reached", max_out, 4);

        run_test("allpad", 32'h1000, 32, 32'd1024, 100, 0, 32, 32, 100, 3, 0);
        check("allpad_nreq0", n_req, 0);
        check("allpad_done_time", done_cyc - start_cyc, 130);

        run_test("restart", 32'h1000, 32, 32'd1024, 4, 4, 32, 32, 50, 4, 1);

        run_test("abort", 32'h1000, 32, 32'd1024, 4, 4, 32, 32, 100, 3, 2);
        run_test("fresh", 32'h3300, 40, 32'd2048, -2, 1, 30, 5, 100, 3, 0);

        for (int t = 0; t < 5; t++) begin
            run_test("rand", $urandom, int'($urandom_range(64, 1)), $urandom,
                     int'($urandom_range(45)) - 5, int'($urandom_range(45)) - 5,
                     int'($urandom_range(40, 1)), int'($urandom_range(40, 1)),
                     int'($urandom_range(100, 20)), int'($urandom_range(8, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
